// File: rtl/lzd_pkg.sv
// Shared widths for the 48-bit leading-zero detector and its 8-bit group slices.
// Constants only; no logic, no latency, no flow control.
package lzd_pkg;
   localparam int LZD_BITS   = 48;
   localparam int P_BITS     = 6;
   localparam int GROUP_BITS = 8;
   localparam int NUM_GROUPS = LZD_BITS / GROUP_BITS;
endpackage

// File: rtl/lzd_8.sv
// lzd_8: combinational 8-bit leading-zero count built from 2-bit leaves and 4-bit merges.
// Zero latency; no flow control. cnt reads 7 when dat is zero and vld is low.
module lzd_8
   import lzd_pkg::*;
(
   input  logic [GROUP_BITS-1:0] dat,
   output logic [2:0]            cnt,
   output logic                  vld
);

   logic [3:0] pair_vld;
   logic [3:0] pair_cnt;
   logic [1:0] quad_vld;
   logic [1:0] quad_cnt [2];

   for (genvar i = 0; i < 4; i++) begin : g_pair
      assign pair_vld[i] = dat[2*i+1] | dat[2*i];
      assign pair_cnt[i] = ~dat[2*i+1];
   end

   // Upper half wins when it holds a one; otherwise its full width counts as zeros.
   for (genvar j = 0; j < 2; j++) begin : g_quad
      assign quad_vld[j] = pair_vld[2*j+1] | pair_vld[2*j];
      assign quad_cnt[j] = pair_vld[2*j+1] ? {1'b0, pair_cnt[2*j+1]}
                                           : {1'b1, pair_cnt[2*j]};
   end

   assign vld = quad_vld[1] | quad_vld[0];
   assign cnt = quad_vld[1] ? {1'b0, quad_cnt[1]} : {1'b1, quad_cnt[0]};

endmodule

// File: rtl/lzd_48.sv
// lzd_48: registered 48-bit leading-zero count (p) and nonzero flag (v); latency 1 cycle.
// No backpressure: a new operand is accepted on every rising edge.
module lzd_48 #(
   parameter int LZD_BITS = lzd_pkg::LZD_BITS,
   parameter int P_BITS   = lzd_pkg::P_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [LZD_BITS-1:0] a,
   output logic [P_BITS-1:0]   p,
   output logic                v
);
   import lzd_pkg::*;

   logic [NUM_GROUPS-1:0] grp_vld;
   logic [2:0]            grp_cnt [NUM_GROUPS];
   logic [P_BITS-1:0]     p_nxt;
   logic                  v_nxt;

   for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
      lzd_8 u_grp (
         .dat (a[gi*GROUP_BITS +: GROUP_BITS]),
         .cnt (grp_cnt[gi]),
         .vld (grp_vld[gi])
      );
   end

   // Scan low to high so the most significant nonzero group has the final say.
   always_comb begin
      p_nxt = '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         if (grp_vld[g]) begin
            p_nxt = P_BITS'((NUM_GROUPS - 1 - g) * GROUP_BITS) + P_BITS'(grp_cnt[g]);
         end
      end
   end

   assign v_nxt = |grp_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p <= '0;
         v <= 1'b0;
      end else begin
         p <= p_nxt;
         v <= v_nxt;
      end
   end

endmodule

// File: tb/tb_lzd_48.sv
// Bench for lzd_48: directed literal vectors plus randomized operands against a bit-scan model.
module tb_lzd_48;

   logic        clk;
   logic        rst_n;
   logic [47:0] a;
   logic [5:0]  p;
   logic        v;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   int exp_p;
   bit exp_v;

   lzd_48 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .p     (p),
      .v     (v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lz_of(logic [47:0] x);
      for (int i = 47; i >= 0; i--) begin
         if (x[i]) return 47 - i;
      end
      return 0;
   endfunction

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: what the outputs must show after each sampling edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_p <= 0;
         exp_v <= 1'b0;
      end else begin
         exp_p <= lz_of(a);
         exp_v <= (a != 48'h0);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_p", int'(p), exp_p);
         chk("model_v", int'(v), int'(exp_v));
      end
   end

   task automatic apply_chk(string nm, logic [47:0] val, int ep, int ev);
      @(negedge clk);
      a = val;
      @(negedge clk);
      chk({nm, "_p"}, int'(p), ep);
      chk({nm, "_v"}, int'(v), ev);
   endtask

   logic [47:0] dir_a [10];
   int          dir_p [10];
   logic [63:0] r64;
   logic [47:0] one;

   initial begin
      dir_a = '{48'h4031213300F8, 48'h003101330005, 48'h001100110005, 48'h103100030005,
                48'h033300310005, 48'h083300310005, 48'h000000000001, 48'h000000000005,
                48'h000000000025, 48'h000000004005};
      dir_p = '{1, 10, 11, 3, 6, 4, 47, 45, 42, 33};

      rst_n = 1'b1;
      a     = {$urandom(), 16'hBEEF};
      #1 rst_n = 1'b0;
      #1;
      chk("reset_p", int'(p), 0);
      chk("reset_v", int'(v), 0);
      a = 48'h800000000000;
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("first_p", int'(p), 0);
      chk("first_v", int'(v), 1);
      cmp_en = 1;

      for (int k = 0; k < 10; k++) apply_chk("dir", dir_a[k], dir_p[k], 1);

      apply_chk("zero", 48'h0, 0, 0);
      apply_chk("after_zero", 48'h000000000002, 46, 1);

      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i <= 48; i++) begin
            @(negedge clk);
            if (i > 0) begin
               chk("walk_p", int'(p), 48 - i);
               chk("walk_v", int'(v), 1);
            end
            if (i < 48) begin
               one = 48'h1 << i;
               a   = (pass == 0) ? one : (one | (one - 48'h1));
            end
         end
      end

      // Drop reset between edges while streaming, then release before the next edge.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a = {$urandom(), 16'h0001};
      end
      @(negedge clk);
      a = 48'h000100000000;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset_p", int'(p), 0);
      chk("mid_reset_v", int'(v), 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_p", int'(p), 15);
      chk("post_reset_v", int'(v), 1);

      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         r64 = {$urandom(), $urandom()};
         r64 = r64 >> $urandom_range(0, 63);
         a   = r64[47:0];
      end
      @(negedge clk);
      @(negedge clk);
      cmp_en = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
